pipe_gap_gen: RTL and testbench

Consumer of the Random32 stream. Turns raw 32-bit pseudo-random words into uniformly distributed pipe-gap vertical positions, buffers them in a small FIFO, and hands them to the pipe-spawning logic over a valid/ready handshake. Also flags a stalled generator, such as one seeded with zero, so the game logic can reseed it.

---
 rtl/pipe_gap_gen_pkg.sv | 16 +
 rtl/pipe_gap_gen_gap_fifo.sv | 84 ++++++++
 rtl/pipe_gap_gen.sv | 86 ++++++++
 tb/tb_pipe_gap_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_gap_gen_pkg.sv
// Shared constants for gap generation and the pipe renderer, plus the FIFO occupancy state type.
package pipe_gap_gen_pkg;
  localparam int GAP_MIN     = 60;
  localparam int GAP_SPAN    = 300;
  localparam int RBITS       = 9;
  localparam int GAP_W       = 10;
  localparam int DEPTH       = 4;
  localparam int STUCK_LIMIT = 16;
  localparam int SCREEN_H    = 480;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_FILLING,
    OCC_FULL
  } occ_state_t;
endpackage

// File: rtl/pipe_gap_gen_gap_fifo.sv
// Small synchronous FIFO with a registered head entry and an occupancy FSM.
// state | meaning: OCC_EMPTY no entries | OCC_FILLING 1..DEPTH-1 entries | OCC_FULL DEPTH entries
module gap_fifo
  import pipe_gap_gen_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_head;
  occ_state_t       r_state;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;

  assign empty    = (r_state == OCC_EMPTY);
  assign full     = (r_state == OCC_FULL);
  assign w_pop    = pop && !flush && !empty;
  assign w_push   = push && !flush && (!full || w_pop);
  assign w_rd_nxt = r_rd + 1'b1;
  assign head     = r_head;
  assign level    = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_head  <= '0;
      r_state <= OCC_EMPTY;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_head  <= '0;
      r_state <= OCC_EMPTY;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= w_rd_nxt;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;

      // Head comes straight from wdata when the new entry becomes the oldest one.
      if (w_push && (empty || (w_pop && r_level == LW'(1))))
        r_head <= wdata;
      else if (w_pop && r_level > LW'(1))
        r_head <= r_mem[w_rd_nxt];

      case (r_state)
        OCC_EMPTY:
          if (w_push) r_state <= (DEPTH == 1) ? OCC_FULL : OCC_FILLING;
        OCC_FILLING:
          if (w_push && !w_pop && r_level == LW'(DEPTH - 1)) r_state <= OCC_FULL;
          else if (w_pop && !w_push && r_level == LW'(1))    r_state <= OCC_EMPTY;
        OCC_FULL:
          if (w_pop && !w_push) r_state <= OCC_FILLING;
        default:
          r_state <= OCC_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/pipe_gap_gen.sv
// Turns Random32 words into uniform pipe-gap positions by rejection sampling,
// queues them for the spawner, and flags a generator that stopped changing.
module pipe_gap_gen
  import pipe_gap_gen_pkg::*;
#(
  parameter int P_GAP_MIN     = GAP_MIN,
  parameter int P_GAP_SPAN    = GAP_SPAN,
  parameter int P_RBITS       = RBITS,
  parameter int P_GAP_W       = GAP_W,
  parameter int P_DEPTH       = DEPTH,
  parameter int P_STUCK_LIMIT = STUCK_LIMIT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [31:0]                number,
  input  logic                       flush,
  input  logic                       gap_ready,
  output logic                       gap_valid,
  output logic [P_GAP_W-1:0]         gap_y,
  output logic [$clog2(P_DEPTH):0]   level,
  output logic                       rng_stuck,
  output logic [15:0]                reject_cnt
);
  localparam int SW = $clog2(P_STUCK_LIMIT + 1);
  localparam logic [P_RBITS:0] SPAN_L = (P_RBITS + 1)'(P_GAP_SPAN);

  logic [31:0]        r_last;
  logic [15:0]        r_reject;
  logic [SW-1:0]      r_stuck_cnt;
  logic               r_stuck;

  logic               w_fresh;
  logic [P_RBITS-1:0] w_r;
  logic               w_accept;
  logic               w_reject;
  logic [P_GAP_W-1:0] w_gap;
  logic [SW-1:0]      w_cnt_nxt;
  logic               w_empty;
  logic               w_full;

  assign w_fresh  = (number != r_last);
  assign w_r      = number[P_RBITS-1:0];
  assign w_accept = w_fresh && ({1'b0, w_r} < SPAN_L);
  assign w_reject = w_fresh && ({1'b0, w_r} >= SPAN_L);
  assign w_gap    = P_GAP_W'(P_GAP_MIN) + P_GAP_W'(w_r);

  always_comb begin
    w_cnt_nxt = r_stuck_cnt;
    if (flush || w_fresh)                    w_cnt_nxt = '0;
    else if (r_stuck_cnt != SW'(P_STUCK_LIMIT)) w_cnt_nxt = r_stuck_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last      <= '0;
      r_reject    <= '0;
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else begin
      r_last      <= number;
      r_stuck_cnt <= w_cnt_nxt;
      r_stuck     <= (w_cnt_nxt == SW'(P_STUCK_LIMIT));
      if (w_reject && r_reject != 16'hFFFF) r_reject <= r_reject + 1'b1;
    end
  end

  gap_fifo #(
    .DEPTH (P_DEPTH),
    .WIDTH (P_GAP_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_accept),
    .pop   (gap_ready),
    .flush (flush),
    .wdata (w_gap),
    .head  (gap_y),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign gap_valid  = !w_empty;
  assign rng_stuck  = r_stuck;
  assign reject_cnt = r_reject;
endmodule

// File: tb/tb_pipe_gap_gen.sv
// Scoreboard bench for pipe_gap_gen: a reference model queues expected gap_y values as draws are driven.
module tb_pipe_gap_gen;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] number = '0;
  logic        flush = 1'b0;
  logic        gap_ready = 1'b0;
  logic        gap_valid;
  logic [9:0]  gap_y;
  logic [2:0]  level;
  logic        rng_stuck;
  logic [15:0] reject_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  m_q[$];
  logic [31:0] m_last;
  int          m_rej;
  int          m_stuck;

  always #5 clk = ~clk;

  pipe_gap_gen dut (
    .clk        (clk),
    .rstn       (rstn),
    .number     (number),
    .flush      (flush),
    .gap_ready  (gap_ready),
    .gap_valid  (gap_valid),
    .gap_y      (gap_y),
    .level      (level),
    .rng_stuck  (rng_stuck),
    .reject_cnt (reject_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_rej   = 0;
    m_stuck = 0;
  endtask

  // Called just after a rising edge; drives one cycle of stimulus and checks both sides of the edge.
  task automatic cycle(input logic [31:0] num, input logic rdy, input logic fl);
    logic       fresh;
    logic [8:0] r;
    bit         p;
    int         sz;
    number = num; gap_ready = rdy; flush = fl;
    chk("gap_valid", gap_valid, (m_q.size() > 0));
    if (m_q.size() > 0) chk("gap_y", gap_y, m_q[0]);
    fresh = (num != m_last);
    r     = num[8:0];
    if (fresh && r >= 9'd300 && m_rej < 16'hFFFF) m_rej++;
    if (fl) begin
      m_q.delete();
      m_stuck = 0;
    end else begin
      sz = m_q.size();
      p  = (sz > 0) && rdy;
      if (p) void'(m_q.pop_front());
      if (fresh && r < 9'd300 && (sz < 4 || p)) m_q.push_back(10'(60 + int'(r)));
      if (fresh) m_stuck = 0;
      else if (m_stuck < 16) m_stuck++;
    end
    m_last = num;
    @(posedge clk); #1;
    chk("level", level, m_q.size());
    chk("reject_cnt", reject_cnt, m_rej);
    chk("rng_stuck", rng_stuck, (m_stuck == 16));
  endtask

  task automatic do_reset();
    rstn = 1'b0; number = '0; flush = 1'b0; gap_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_valid", gap_valid, 0);
    chk("rst_gap_y", gap_y, 0);
    chk("rst_level", level, 0);
    chk("rst_stuck", rng_stuck, 0);
    chk("rst_reject", reject_cnt, 0);
    rstn = 1'b1;
  endtask

  task automatic drain(input logic [31:0] num);
    for (int i = 0; i < 6; i++) cycle(num, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    do_reset();

    // first accepted draw, then a reject followed by the top in-range value
    cycle(32'h4789FA12, 1'b0, 1'b0);
    cycle(32'h4789FA12, 1'b0, 1'b0);
    chk("t1_gap_y", gap_y, 78);
    cycle(32'h000001FF, 1'b0, 1'b0);
    cycle(32'h0000012B, 1'b0, 1'b0);
    drain(32'h0000012B);

    // fill to capacity, overflow drop, then drain in order
    for (int i = 0; i < 5; i++) cycle(32'h1000_0000 | i, 1'b0, 1'b0);
    chk("t3_level_full", level, 4);
    drain(32'h1000_0004);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) cycle(32'h2000_0000 | i, 1'b0, 1'b0);
    cycle(32'h2000_000A, 1'b1, 1'b0);
    chk("t4_level", level, 4);
    drain(32'h2000_000A);

    // zero seed after reset raises rng_stuck, a change clears it
    do_reset();
    for (int i = 0; i < 16; i++) cycle(32'h0, 1'b0, 1'b0);
    chk("t5_stuck", rng_stuck, 1);
    cycle(32'h12345678, 1'b0, 1'b0);
    cycle(32'h12345678, 1'b0, 1'b0);
    chk("t5_gap_y", gap_y, 180);

    // flush wins over push and pop
    cycle(32'h3000_0005, 1'b0, 1'b0);
    cycle(32'h3000_0006, 1'b1, 1'b1);
    chk("t6_flush_valid", gap_valid, 0);

    // random traffic with frequent repeats and rare flushes
    v = 32'h0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0) v = $urandom;
      cycle(v, 1'($urandom_range(1)), ($urandom_range(40) == 0));
    end
    for (int i = 0; i < 20; i++) cycle(v, 1'b0, 1'b0);

    // async reset in the middle of traffic
    cycle(32'h4000_0001, 1'b0, 1'b0);
    cycle(32'h4000_0002, 1'b0, 1'b0);
    #3 rstn = 1'b0;
    #1;
    chk("async_valid", gap_valid, 0);
    chk("async_gap_y", gap_y, 0);
    chk("async_level", level, 0);
    chk("async_reject", reject_cnt, 0);
    chk("async_stuck", rng_stuck, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
